// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_mem_pkg
// Purpose  : Memory-op codes, MEM-stage FSM state type and op classifiers
//            shared by the MIPS MEM stage and its load aligner.
// Revision : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LBU  = 4'd2;
  localparam logic [3:0] MEM_LH   = 4'd3;
  localparam logic [3:0] MEM_LHU  = 4'd4;
  localparam logic [3:0] MEM_LW   = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Interface : memory_stage_if
// Purpose   : req/ack data-memory bus between the MEM stage (master) and the
//             data memory (slave). ack is a one-cycle completion pulse and
//             rdata is valid alongside it.
// Revision  : 1.0  initial release
// ============================================================================
interface memory_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, be, addr, wdata, input ack, rdata);
  modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface : memory_stage_if
`default_nettype wire

// File: rtl/memory_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Purpose  : Combinational big-endian lane select and sign/zero extension of
//            load data. Byte offset 0 is bits 31:24, halfword offset 0 is
//            bits 31:16. Halfwords use only offset[1]; words ignore offset.
// Revision : 1.0  initial release
// ============================================================================
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword lane, then extend according to the op.
  always_comb begin
    byte_sel = 8'd0;
    ext      = 32'd0;
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      MEM_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ext = {24'd0, byte_sel};
      MEM_LH:  ext = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ext = {16'd0, half_sel};
      MEM_LW:  ext = rdata;
      default: ext = 32'd0;
    endcase
  end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : MIPS MEM stage. Non-memory ops pass straight through to
//            writeback; loads/stores run on the req/ack data bus through an
//            IDLE -> BUSY -> DONE FSM while stall_req freezes IF..EX/MEM, so
//            the EX/MEM inputs stay stable for the whole access.
// Config   : MEM_ALIGN_CHECK_EN - when defined, misaligned halfword/word
//            accesses are dropped and flagged on addr_err instead of being
//            issued at the aligned address.
// Revision : 1.0  initial release
// ============================================================================
module memory_stage
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           dest_addr,
  input  logic                 write_or_not,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          store_data,
  input  logic [3:0]           mem_op,
  memory_stage_if.master       dmem,
  output logic                 stall_req,
  output logic [4:0]           dest_addr_out,
  output logic                 write_or_not_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 addr_err,
`endif
  output logic [31:0]          wdata_out
);

  state_t      state_q, state_d;
  logic [31:0] load_q;
  logic        req_q;
  logic [31:0] load_ext;
  logic        op_load, op_store, misaligned, start;

  assign op_load  = is_load(mem_op);
  assign op_store = is_store(mem_op);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half(mem_op) && alu_result[0]) ||
                      (is_word(mem_op) && (alu_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Illegal op codes fall outside both classes and so behave as MEM_NONE.
  assign start = (op_load || op_store) && !misaligned;

  mem_load_align u_load_align (
    .rdata  (dmem.rdata),
    .offset (alu_result[1:0]),
    .op     (mem_op),
    .ext    (load_ext)
  );

  // Next-state: DONE always returns to IDLE because the pipeline advances on
  // that edge, so the same op is never seen twice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (dmem.ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request flag and captured load data; ack outside BUSY is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= 32'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == BUSY);
      if ((state_q == BUSY) && dmem.ack) load_q <= load_ext;
    end
  end

  // Output decode: bus drive in BUSY, bubble while stalled, writeback in DONE.
  always_comb begin
    stall_req        = 1'b0;
    dest_addr_out    = 5'd0;
    write_or_not_out = 1'b0;
    wdata_out        = 32'd0;
    dmem.req         = 1'b0;
    dmem.we          = 1'b0;
    dmem.be          = 4'd0;
    dmem.addr        = '0;
    dmem.wdata       = 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
    addr_err         = 1'b0;
`endif
    if (!rst) begin
      dest_addr_out = dest_addr;
      wdata_out     = alu_result;
      case (state_q)
        IDLE: begin
          if (start) begin
            stall_req = 1'b1;
          end else begin
            write_or_not_out = write_or_not && !misaligned;
`ifdef MEM_ALIGN_CHECK_EN
            addr_err = misaligned;
`endif
          end
        end
        BUSY: begin
          stall_req  = 1'b1;
          dmem.req   = req_q;
          dmem.we    = op_store;
          dmem.addr  = {alu_result[ADDR_W-1:2], 2'b00};
          case (mem_op)
            MEM_SB: begin
              dmem.be    = 4'b1000 >> alu_result[1:0];
              dmem.wdata = {4{store_data[7:0]}};
            end
            MEM_SH: begin
              dmem.be    = alu_result[1] ? 4'b0011 : 4'b1100;
              dmem.wdata = {2{store_data[15:0]}};
            end
            MEM_SW: begin
              dmem.be    = 4'b1111;
              dmem.wdata = store_data;
            end
            default: begin
              dmem.be    = 4'b1111;
              dmem.wdata = 32'd0;
            end
          endcase
        end
        DONE: begin
          if (op_load) begin
            write_or_not_out = write_or_not;
            wdata_out        = load_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : memory_stage
`default_nettype wire
